ring_freq_counter: RTL and testbench

//   Measures the frequency of the tapped inverter-ring output in the clk domain.

---
 rtl/ring_freq_counter_pkg.sv | 19 +
 rtl/ring_edge_sync.sv | 32 +++
 rtl/ring_freq_counter.sv | 128 ++++++++++++
 tb/tb_ring_freq_counter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_freq_counter_pkg.sv
// Shared state encoding and defaults for the ring-oscillator frequency counter.
package ring_freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_DONE = 2'd3
  } fc_state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int CNT_W_DEF         = 16;
  localparam int GATE_LOG2_MIN_DEF = 8;

  function automatic logic state_busy(input fc_state_e st);
    return (st == ST_ARM) || (st == ST_GATE);
  endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Synchroniser for the free-running ring output plus rising-edge detect.
// Kept as its own hierarchy so the synchroniser flops can be targeted by constraints.
module ring_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
    s_prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_prev_q;

endmodule

// File: rtl/ring_freq_counter.sv
// Counts synchronised ring rising edges over a 2^(GATE_LOG2_MIN+gate_sel) cycle
// window and presents the result with a one-cycle strobe.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | SYNC_STAGES+1 cycles flushing stale synchroniser samples
// GATE  | counting rises for exactly W cycles
// DONE  | result registered, count_valid high, start may re-arm directly
module ring_freq_counter
  import ring_freq_counter_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_LOG2_MIN = GATE_LOG2_MIN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring_in,
  input  logic             start,
  input  logic [1:0]       gate_sel,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  // Sized to hold W-1 for the longest window (gate_sel=3) as well as the ARM count.
  localparam int TIMER_W = GATE_LOG2_MIN + 3;

  fc_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         gsel_q, gsel_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [TIMER_W-1:0] gate_last;
  logic               rise;

  ring_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ring_in),
    .rise     (rise)
  );

  // For the widest window the shift wraps to zero, giving all-ones = W-1.
  always_comb begin
    gate_last = (TIMER_W'(1) << (GATE_LOG2_MIN + int'(gsel_q))) - TIMER_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gsel_d     = gsel_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d    = ST_ARM;
          gsel_d     = gate_sel;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          timer_d    = TIMER_W'(SYNC_STAGES);
        end
      end
      ST_ARM: begin
        if (timer_q == '0) begin
          state_d = ST_GATE;
          timer_d = gate_last;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_GATE: begin
        if (rise) begin
          if (&edge_cnt_q) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        // The final window cycle still counts, so the result takes the updated value.
        if (timer_q == '0) begin
          state_d    = ST_DONE;
          count_d    = edge_cnt_d;
          overflow_d = sat_d;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      gsel_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gsel_q     <= gsel_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy        = state_busy(state_q);
  assign count_valid = (state_q == ST_DONE);
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ring_freq_counter.sv
// Scoreboard bench: a 16-bit and a 4-bit counter share one ring and control stream.
module tb_ring_freq_counter;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ring_in;
  logic        start = 1'b0;
  logic [1:0]  gate_sel = 2'd0;
  logic        busy, count_valid, overflow;
  logic [15:0] count;
  logic        busy4, count_valid4, overflow4;
  logic [3:0]  count4;

  logic ring_osc = 1'b0;
  logic ring_run = 1'b1;
  logic ring_stuck = 1'b0;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_strobe = 0;
  exp_t q16[$];
  exp_t q4[$];

  ring_freq_counter dut (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start), .gate_sel(gate_sel),
    .busy(busy), .count(count), .count_valid(count_valid), .overflow(overflow)
  );

  ring_freq_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start), .gate_sel(gate_sel),
    .busy(busy4), .count(count4), .count_valid(count_valid4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // Ring period 8 clk; edges offset so they never coincide with a clk edge.
  initial begin
    #13;
    forever #40 ring_osc = ~ring_osc;
  end
  assign ring_in = ring_run ? ring_osc : ring_stuck;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && count_valid) begin
      exp_t e;
      n_strobe++;
      total++;
      if (q16.size() == 0) begin
        bad++;
        $display("FAIL strobe16_unexpected: got strobe at cyc=%0d count=%0d, required no strobe", cyc, count);
      end else begin
        e = q16.pop_front();
        if (cyc !== e.cyc || count !== e.cnt || overflow !== e.ovf) begin
          bad++;
          $display("FAIL result16: got cyc=%0d count=%0d ovf=%0b, required cyc=%0d count=%0d ovf=%0b",
                   cyc, count, overflow, e.cyc, e.cnt, e.ovf);
        end
      end
    end
    if (rst_n && count_valid4) begin
      exp_t e;
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL strobe4_unexpected: got strobe at cyc=%0d count=%0d, required no strobe", cyc, count4);
      end else begin
        e = q4.pop_front();
        if (cyc !== e.cyc || count4 !== e.cnt[3:0] || overflow4 !== e.ovf) begin
          bad++;
          $display("FAIL result4: got cyc=%0d count=%0d ovf=%0b, required cyc=%0d count=%0d ovf=%0b",
                   cyc, count4, overflow4, e.cyc, e.cnt[3:0], e.ovf);
        end
      end
    end
  end

  // Drives a start for the coming edge and records what both counters must report.
  task automatic issue_start(input logic [1:0] gs, input bit running);
    exp_t e16, e4;
    int   w, edges;
    w     = 1 << (8 + int'(gs));
    edges = running ? w / 8 : 0;
    e16.cyc = cyc + 4 + w;
    e16.cnt = 16'(edges);
    e16.ovf = 1'b0;
    e4.cyc  = e16.cyc;
    e4.cnt  = (edges > 15) ? 16'd15 : 16'(edges);
    e4.ovf  = (edges > 15);
    q16.push_back(e16);
    q4.push_back(e4);
    gate_sel = gs;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (q16.size() != 0 || q4.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d results pending, required 0", tag, q16.size() + q4.size());
      q16.delete();
      q4.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, count, count_valid, overflow} !== 19'd0) begin
      bad++;
      $display("FAIL reset16: got busy=%0b count=%0d valid=%0b ovf=%0b, required all 0",
               busy, count, count_valid, overflow);
    end
    total++;
    if ({busy4, count4, count_valid4, overflow4} !== 7'd0) begin
      bad++;
      $display("FAIL reset4: got busy=%0b count=%0d valid=%0b ovf=%0b, required all 0",
               busy4, count4, count_valid4, overflow4);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    issue_start(2'd0, 1'b1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %0b, required 1", busy);
    end
    wait_idle(400, "basic");
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (count !== 16'd32 || overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold16: got count=%0d ovf=%0b busy=%0b, required 32/0/0", count, overflow, busy);
    end
    total++;
    if (count4 !== 4'd15 || overflow4 !== 1'b1) begin
      bad++;
      $display("FAIL hold4: got count=%0d ovf=%0b, required 15/1", count4, overflow4);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    issue_start(2'd3, 1'b1);
    for (int i = 0; i < 2300 && !seen; i++) begin
      @(negedge clk);
      if (count_valid) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_first_strobe: got none in 2300 cycles, required one");
    end else begin
      issue_start(2'd3, 1'b1);
    end
    wait_idle(2300, "b2b");
  endtask

  task automatic test_stuck();
    for (int lvl = 0; lvl < 2; lvl++) begin
      ring_stuck = lvl[0];
      ring_run   = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      issue_start(2'd0, 1'b0);
      wait_idle(400, "stuck");
      total++;
      if (count !== 16'd0 || overflow !== 1'b0 || count4 !== 4'd0 || overflow4 !== 1'b0) begin
        bad++;
        $display("FAIL stuck_level%0d: got count=%0d ovf=%0b count4=%0d ovf4=%0b, required 0/0/0/0",
                 lvl, count, overflow, count4, overflow4);
      end
    end
    ring_run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_start();
    issue_start(2'd0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      gate_sel = 2'd3;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      gate_sel = 2'd0;
      @(posedge clk);
      #1;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_during_gate: got %0b, required 1", busy);
    end
    wait_idle(400, "busy_start");
    repeat (300) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int strobes_before;
    issue_start(2'd0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || count !== 16'd0 || count_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%0b count=%0d valid=%0b ovf=%0b, required 0/0/0/0",
               busy, count, count_valid, overflow);
    end
    q16.delete();
    q4.delete();
    strobes_before = n_strobe;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    total++;
    if (n_strobe !== strobes_before || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got %0d strobes busy=%0b, required 0 strobes busy=0",
               n_strobe - strobes_before, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stuck();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no completion by 500us, required completion");
    $fatal(1);
  end

endmodule
